// File: rtl/reg_wr_arbiter_if.sv
// Bundle for the shared register write port: requester beats in, register write out.
// master = requester side, slave = arbiter side.
interface reg_wr_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ*32-1:0] req_addr;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [31:0]         reg_addr;
    logic [31:0]         reg_wr_data;
    logic                reg_wr;
    logic [IDW-1:0]      grant_id;
    logic                busy;
    logic                timeout_err;

    modport master (
        output req_valid, req_last, req_addr, req_data,
        input  req_ready, reg_addr, reg_wr_data, reg_wr, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data,
        output req_ready, reg_addr, reg_wr_data, reg_wr, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter in front of the control-register write port.
// Single beats re-arbitrate every cycle; a beat with req_last=0 locks the port
// to its requester until that requester's req_last beat.
// Optional macro REG_WR_ARB_TIMEOUT_EN: force-release a locked burst that
// stalls for MAX_IDLE cycles and pulse timeout_err.
module reg_wr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_IDLE = 15
) (
    input  logic               clk,
    input  logic               rst,
    reg_wr_arbiter_if.slave    bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic [IDW-1:0]         win_id, acc_id;
    logic                   win_found;
    logic                   accept;
    logic                   timeout_hit;
    logic [N_REQ-1:0]       ready;
    logic [N_REQ-1:0][31:0] addr_v, data_v;
    logic [31:0]            reg_addr_q, reg_data_q;
    logic                   reg_wr_q, busy_q;

    // Legal configurations only; nothing is built here.
    if (N_REQ < 2 || N_REQ > 8 || MAX_IDLE < 1) begin : g_bad_params
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_v[i] = bus.req_addr[32*i +: 32];
        assign data_v[i] = bus.req_data[32*i +: 32];
    end

    // k-th requester in search order starting at p.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
        return IDW'((int'(p) + k) % N_REQ);
    endfunction

    // Next pointer after owner g, wrapping at N_REQ-1.
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] g);
        return (g == IDW'(N_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    // First valid requester at or after ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.req_valid[rr_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = rr_idx(ptr_q, k);
            end
        end
    end

    // Next state, pointer, owner and the combinational ready vector.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ready   = '0;
        accept  = 1'b0;
        acc_id  = gid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready[win_id] = 1'b1;
                    accept        = 1'b1;
                    acc_id        = win_id;
                    gid_d         = win_id;
                    if (bus.req_last[win_id]) ptr_d   = rr_next(win_id);
                    else                      state_d = OWN;
                end
            end
            OWN: begin
                if (timeout_hit) begin
                    // Forced release: a beat offered this cycle is refused.
                    state_d = IDLE;
                    ptr_d   = rr_next(gid_q);
                end else if (bus.req_valid[gid_q]) begin
                    ready[gid_q] = 1'b1;
                    accept       = 1'b1;
                    if (bus.req_last[gid_q]) begin
                        state_d = IDLE;
                        ptr_d   = rr_next(gid_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Nothing is handshaken while reset is held.
        if (rst) ready = '0;
    end

    // Arbitration state and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gid_q      <= '0;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            reg_wr_q <= accept;
            busy_q   <= (state_d == OWN) || accept;
            if (accept) begin
                reg_addr_q <= addr_v[acc_id];
                reg_data_q <= data_v[acc_id];
            end
        end
    end

`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_IDLE + 1);

    logic [CW-1:0] stall_q;
    logic          tmo_q;

    assign timeout_hit     = (state_q == OWN) && (stall_q == CW'(MAX_IDLE));
    assign bus.timeout_err = tmo_q;

    // Stall counter: cleared outside OWN (so on OWN entry) and on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= timeout_hit;
            if (accept || state_q != OWN)
                stall_q <= '0;
            else if (!bus.req_valid[gid_q] && !timeout_hit)
                stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.req_ready   = ready;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wr_data = reg_data_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Round-robin arbiter that shares the single register write port (`reg_addr` / `reg_wr_data` / `reg_wr`) of the control-register block between several requesters, such as the host bus bridge, the op sequencer and debug.
- Each requester issues writes over a valid/ready handshake, as single beats or as locked bursts terminated by `req_last`.
- The winning beat is driven onto the register port as a registered one-cycle write pulse.
- The block sits directly in front of the register block. It is the only driver of its write port.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_IDLE`, 15: stall cycles allowed inside a locked burst before forced release. Used only with the timeout feature.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `N_REQ`: per-requester beat valid.
- `req_last` in `N_REQ`: beat is the last beat of its burst. A single write has `req_last`=1.
- `req_addr` in `N_REQ*32`: packed addresses. Requester i occupies `[32*i+31:32*i]`.
- `req_data` in `N_REQ*32`: packed write data, same packing as `req_addr`.
- `req_ready` out `N_REQ`: beat accepted this cycle. Combinational, at most one bit set.
- `reg_addr` out 32: register write address.
- `reg_wr_data` out 32: register write data.
- `reg_wr` out 1: one-cycle write strobe.
- `grant_id` out `$clog2(N_REQ)`: index of the current or last owner.
- `busy` out 1: arbiter is in OWN state, or `reg_wr` is high.
- `timeout_err` out 1: one-cycle pulse on a forced release. Tied to 0 without the macro.

## Operation
- States:
  - IDLE: no owner.
  - OWN: requester `grant_id` holds a locked burst.
- Priority pointer `ptr`:
  - Reset value 0.
  - Search order is `ptr`, `ptr+1`, … modulo `N_REQ`.
- IDLE:
  - If any `req_valid` is set, the first valid requester in search order wins. Its `req_ready` is 1 in the same cycle and the beat is accepted.
  - `grant_id` ← winner.
  - If `req_last`=1: stay in IDLE and set `ptr` ← winner+1 (wraps from `N_REQ`-1 to 0).
  - If `req_last`=0: go to OWN.
- OWN:
  - `req_ready[grant_id]` = `req_valid[grant_id]`. All other `req_ready` bits are 0.
  - On an accepted beat with `req_last`=1: go to IDLE and set `ptr` ← `grant_id`+1.
  - On a cycle with no valid beat: nothing is written and the state holds.
- Accepted beat, next cycle:
  - `reg_wr`=1.
  - `reg_addr` and `reg_wr_data` carry the beat's address and data.
- No accepted beat: `reg_wr`=0, and `reg_addr` / `reg_wr_data` hold their previous values.
- At most one beat is accepted per cycle. Back-to-back beats produce back-to-back `reg_wr` pulses with no bubble.
- Other requesters asserting valid during OWN wait without loss. Their valid and payload must be held stable until ready.
- Reset values:
  - `reg_wr`, `reg_addr`, `reg_wr_data`, `grant_id`, `busy`, `timeout_err` all 0.
  - State IDLE, `ptr` 0.
  - `req_ready` is all-zero while `rst` is high.
- Reset mid-burst: state returns to IDLE next cycle. A write registered in the reset cycle is dropped, so `reg_wr` is 0 after reset.

## Timing
- Latency: beat accepted in cycle T → `reg_wr` high in cycle T+1, for exactly one cycle per beat.
- IDLE→OWN→IDLE: a burst of k beats with no stalls occupies k cycles. A new arbitration can be won in the cycle after the last beat.
- The `req_ready` path is combinational from `req_valid`, state and `ptr`. All other outputs are registered.

## Configuration
- Macro `REG_WR_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter clears on every accepted beat and on entry to OWN. It increments on each OWN cycle with `req_valid[grant_id]`=0.
  - When the counter reaches `MAX_IDLE`: force IDLE, set `ptr` ← `grant_id`+1, and pulse `timeout_err` in the following cycle.
  - A beat presented in that same cycle is not accepted.
- Undefined:
  - No counter is built, and `timeout_err` is tied to 0.
  - OWN is held indefinitely until the owner's `req_last` beat.

## Test plan
- Reset, then requester 2 sends a single beat (addr 10, data 0x3, last=1) → `req_ready[2]` is high in the same cycle. Next cycle `reg_wr`=1, `reg_addr`=10, `reg_wr_data`=3, `grant_id`=2.
- All four requesters hold valid single beats continuously → grants follow the order 0,1,2,3,0, with `reg_wr` high every cycle.
- Requester 1 sends a 3-beat burst while requester 0 is valid → three consecutive writes from requester 1, then requester 0 wins next.
- Requester 3 stalls for 5 cycles mid-burst with `MAX_IDLE`=15 → no foreign grant and no `reg_wr` during the stall, and the burst then completes. With the macro defined and a 15-cycle stall → `timeout_err` pulses and requester 0 is granted next.
- `rst` asserted during the second beat of a burst → `reg_wr`=0 and `busy`=0 after reset, and the next arbitration starts from requester 0.
- `N_REQ`=2, requester 1 wins → `ptr` wraps to 0, and a simultaneous request from both requesters is granted to requester 0.
